uart_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares the single uart_top_tx transmitter among NUM_REQ byte requesters.
- Sits between client logic and the transmitter's valid_in/data_in pins, and is fed the same parity_sel, stop_sel and baud_divisor configuration.
- The transmitter has no ready/busy output, so this block times each frame itself from the configuration. It issues a new valid pulse only after the previous frame plus a guard gap has elapsed.

---
 rtl/uart_tx_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters; times each
// frame from the line configuration. Optional packet lock enabled by `define UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [NUM_REQ*8-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]   i_req_lock,
    input  logic                 i_parity_sel,
    input  logic                 i_stop_sel,
    input  logic [11:0]          i_baud_divisor,
    output logic [NUM_REQ-1:0]   o_ack,
    output logic                 o_tx_valid_out,
    output logic [7:0]           o_tx_data_out,
    output logic [2:0]           o_grant_id,
    output logic                 o_busy
);

    localparam int unsigned PtrW = $clog2(NUM_REQ);
    localparam int unsigned IdxW = PtrW + 1;
    localparam int unsigned GapW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GapW-1:0] GapLoad = (GUARD_CYCLES > 0) ? GapW'(GUARD_CYCLES - 1) : '0;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLaunch = 2'd1;
    localparam logic [1:0] StFrame  = 2'd2;
    localparam logic [1:0] StGap    = 2'd3;

    logic [1:0]         r_state;
    logic [PtrW-1:0]    r_rr_ptr;
    logic [PtrW-1:0]    r_grant;
    logic [7:0]         r_data;
    logic [15:0]        r_frame_cnt;
    logic [GapW-1:0]    r_gap_cnt;

    logic               w_rr_found;
    logic [PtrW-1:0]    w_rr_sel;
    logic [IdxW-1:0]    w_idx;
    logic               w_have;
    logic [PtrW-1:0]    w_sel;
    logic [7:0]         w_sel_data;
    logic [PtrW-1:0]    w_next_ptr;
    logic               w_rr_adv;
    logic               w_to_idle;
    logic [11:0]        w_div;
    logic [3:0]         w_frame_bits;
    logic [15:0]        w_frame_load;
    logic [NUM_REQ-1:0] w_ack;

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_sel   = '0;
        w_idx      = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_idx = {1'b0, r_rr_ptr} + IdxW'(i);
            if (w_idx >= IdxW'(NUM_REQ)) begin
                w_idx = w_idx - IdxW'(NUM_REQ);
            end
            if (!w_rr_found && i_req[w_idx[PtrW-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_sel   = w_idx[PtrW-1:0];
            end
        end
    end

`ifdef UART_ARB_LOCK_EN
    logic [4:0] r_lock_cnt;
    logic       r_lock_pend;
    logic       r_lock_grant;
    logic       w_use_lock;
    logic       w_lock_ok;

    assign w_use_lock = r_lock_pend && i_req[r_grant];
    assign w_lock_ok  = i_req_lock[r_grant] && i_req[r_grant] && (r_lock_cnt < 5'd16);
    assign w_have     = w_rr_found;
    assign w_sel      = w_use_lock ? r_grant : w_rr_sel;
    assign w_rr_adv   = !r_lock_grant;

    // r_lock_cnt counts consecutive frames of one requester; a fresh RR grant restarts it at 1.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lock_cnt   <= 5'd0;
            r_lock_pend  <= 1'b0;
            r_lock_grant <= 1'b0;
        end else begin
            if (r_state == StIdle && w_have) begin
                r_lock_grant <= w_use_lock;
            end
            if (r_state == StIdle && (w_have || !i_req[r_grant])) begin
                r_lock_pend <= 1'b0;
            end
            if (r_state == StLaunch) begin
                r_lock_cnt <= r_lock_grant ? r_lock_cnt + 5'd1 : 5'd1;
            end
            if (w_to_idle) begin
                r_lock_pend <= w_lock_ok;
            end
        end
    end
`else
    logic w_unused_lock;

    assign w_unused_lock = ^i_req_lock;
    assign w_have        = w_rr_found;
    assign w_sel         = w_rr_sel;
    assign w_rr_adv      = 1'b1;
`endif

    assign w_sel_data   = i_req_data[{w_sel, 3'b000} +: 8];
    assign w_next_ptr   = (r_grant == PtrW'(NUM_REQ - 1)) ? '0 : r_grant + PtrW'(1);
    assign w_div        = (i_baud_divisor == 12'd0) ? 12'd1 : i_baud_divisor;
    assign w_frame_bits = 4'd10 + {3'd0, i_parity_sel} + {3'd0, i_stop_sel};
    assign w_frame_load = ({12'd0, w_frame_bits} * {4'd0, w_div}) - 16'd1;
    assign w_to_idle    = ((r_state == StFrame) && (r_frame_cnt == 16'd0) && (GUARD_CYCLES == 0))
                       || ((r_state == StGap) && (r_gap_cnt == '0));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_data      <= 8'd0;
            r_frame_cnt <= 16'd0;
            r_gap_cnt   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_have) begin
                        r_grant <= w_sel;
                        r_data  <= w_sel_data;
                        r_state <= StLaunch;
                    end
                end
                StLaunch: begin
                    if (w_rr_adv) begin
                        r_rr_ptr <= w_next_ptr;
                    end
                    r_frame_cnt <= w_frame_load;
                    r_state     <= StFrame;
                end
                StFrame: begin
                    if (r_frame_cnt == 16'd0) begin
                        if (GUARD_CYCLES > 0) begin
                            r_gap_cnt <= GapLoad;
                            r_state   <= StGap;
                        end else begin
                            r_state <= StIdle;
                        end
                    end else begin
                        r_frame_cnt <= r_frame_cnt - 16'd1;
                    end
                end
                StGap: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= StIdle;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GapW'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        w_ack = '0;
        if (r_state == StLaunch) begin
            w_ack[r_grant] = 1'b1;
        end
    end

    assign o_ack          = w_ack;
    assign o_tx_valid_out = (r_state == StLaunch);
    assign o_tx_data_out  = r_data;
    assign o_grant_id     = 3'(r_grant);
    assign o_busy         = (r_state != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, GUARD_CYCLES=2).
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_lock;
    logic        parity_sel;
    logic        stop_sel;
    logic [11:0] baud_divisor;
    logic [3:0]  ack;
    logic        tx_valid_out;
    logic [7:0]  tx_data_out;
    logic [2:0]  grant_id;
    logic        busy;

    int checks;
    int failures;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .GUARD_CYCLES (2)
    ) u_dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_req          (req),
        .i_req_data     (req_data),
        .i_req_lock     (req_lock),
        .i_parity_sel   (parity_sel),
        .i_stop_sel     (stop_sel),
        .i_baud_divisor (baud_divisor),
        .o_ack          (ack),
        .o_tx_valid_out (tx_valid_out),
        .o_tx_data_out  (tx_data_out),
        .o_grant_id     (grant_id),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Steps until a launch pulse is seen; returns the step count, or -1 if none within the bound.
    task automatic wait_launch(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!tx_valid_out && n < 500);
        if (!tx_valid_out) n = -1;
    endtask

    // Called on a launch cycle; returns how many cycles busy stayed high, including launch.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 1000) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        int n;
        int exp_g;
        int nl;
        checks       = 0;
        failures     = 0;
        clk          = 1'b0;
        reset        = 1'b1;
        req          = 4'b0000;
        req_data     = 32'h0;
        req_lock     = 4'b0000;
        parity_sel   = 1'b0;
        stop_sel     = 1'b0;
        baud_divisor = 12'd4;
        step(2);
        reset = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_valid", tx_valid_out, 0);
        check("reset_ack", ack, 0);
        check("reset_grant", grant_id, 0);
        check("reset_data", tx_data_out, 0);

        // Single requester, 10-bit frame at divisor 4.
        req_data = 32'h0000_A500;
        req      = 4'b0010;
        wait_launch(n);
        check("single_latency", n, 1);
        check("single_ack", ack, 4'b0010);
        check("single_data", tx_data_out, 8'hA5);
        check("single_grant", grant_id, 1);
        req = 4'b0000;
        step(1);
        check("single_ack_in_frame", ack, 0);
        check("single_valid_in_frame", tx_valid_out, 0);
        wait_idle(n);
        check("single_busy_len", n + 1, 43);

        // Frame length with parity and two stop bits at divisor 3, continuous request.
        parity_sel   = 1'b1;
        stop_sel     = 1'b1;
        baud_divisor = 12'd3;
        req_data     = 32'h005C_0000;
        req          = 4'b0100;
        wait_launch(n);
        check("frame_first_latency", n, 1);
        check("frame_first_data", tx_data_out, 8'h5C);
        wait_launch(n);
        check("frame_spacing", n, 40);
        check("frame_second_ack", ack, 4'b0100);
        req = 4'b0000;
        wait_idle(n);

        // Fairness from rr_ptr=0 with all requesters active.
        reset = 1'b1;
        step(1);
        reset        = 1'b0;
        parity_sel   = 1'b0;
        stop_sel     = 1'b0;
        baud_divisor = 12'd1;
        req_data     = 32'h1312_1110;
        req          = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_launch(n);
            exp_g = i % 4;
            check("fair_grant", grant_id, exp_g);
            check("fair_ack", ack, 32'(1) << exp_g);
            check("fair_data", tx_data_out, 32'h10 + exp_g);
        end
        req = 4'b0000;
        wait_idle(n);

        // Divisor 0 acts as 1; a mid-frame divisor change must not stretch the frame.
        baud_divisor = 12'd0;
        req_data     = 32'h0000_0077;
        req          = 4'b0001;
        wait_launch(n);
        check("div0_latency", n, 1);
        req = 4'b0000;
        step(1);
        baud_divisor = 12'd100;
        wait_idle(n);
        check("div0_busy_len", n + 1, 13);

        // Reset during FRAME, then arbitration must restart from rr_ptr=0.
        baud_divisor = 12'd4;
        req_data     = 32'h4433_2211;
        req          = 4'b0100;
        wait_launch(n);
        req = 4'b0000;
        step(5);
        check("midreset_busy_before", busy, 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("midreset_busy", busy, 0);
        check("midreset_valid", tx_valid_out, 0);
        check("midreset_ack", ack, 0);
        check("midreset_grant", grant_id, 0);
        check("midreset_data", tx_data_out, 0);
        req = 4'b1010;
        wait_launch(n);
        check("midreset_rr_grant", grant_id, 1);
        check("midreset_rr_data", tx_data_out, 8'h22);
        req = 4'b0000;
        wait_idle(n);

        // Packet lock on requester 0 while 0 and 1 both request.
        reset = 1'b1;
        step(1);
        reset        = 1'b0;
        baud_divisor = 12'd1;
        req_data     = 32'h0000_CDAB;
        req_lock     = 4'b0001;
        req          = 4'b0011;
`ifdef UART_ARB_LOCK_EN
        nl = 18;
`else
        nl = 4;
`endif
        for (int i = 0; i < nl; i++) begin
            wait_launch(n);
`ifdef UART_ARB_LOCK_EN
            exp_g = (i == 16) ? 1 : 0;
`else
            exp_g = i % 2;
`endif
            check("lock_grant", grant_id, exp_g);
        end
        req      = 4'b0000;
        req_lock = 4'b0000;
        wait_idle(n);
        check("final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
